// File: rtl/spi_clk_pkg.sv
// Shared types and defaults for the SPI serial-clock generator.
// Holds the FSM state encoding and the default parameter values.
package spi_clk_pkg;

  localparam int DEF_DIV_WIDTH = 8;
  localparam int DEF_MAX_BITS  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    GUARD = 2'd2
  } state_e;

endpackage

// File: rtl/sclk_prescaler.sv
// Half-period counter: counts 0..limit and wraps.
// Flags the terminal count.
module sclk_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc = (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock generator with CPOL/CPHA strobes,
// a trailing guard half-period and abort.
module spi_sclk_gen
  import spi_clk_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int MAX_BITS  = DEF_MAX_BITS,
  localparam int CNT_WIDTH = $clog2(MAX_BITS + 1)
) (
  input  logic                 clockIn,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic [CNT_WIDTH-1:0] n_bits,
  input  logic                 cpol,
  input  logic                 cpha,
  output logic                 sclk,
  output logic                 sample_strobe,
  output logic                 shift_strobe,
  output logic                 busy,
  output logic                 done
);

  localparam int EW = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] MAX_N = CNT_WIDTH'(MAX_BITS);

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] nbits_q, nbits_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic                 phase_q, phase_d;
  logic [EW-1:0]        edge_q, edge_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 smp_q, smp_d;
  logic                 shf_q, shf_d;

  logic                 tc;
  logic                 clr;
  logic                 nbits_ok;
  logic                 lead;

  sclk_prescaler #(
    .W(DIV_WIDTH)
  ) u_pre (
    .clk   (clockIn),
    .rst_n (reset),
    .clear (clr),
    .en    (state_q != IDLE),
    .limit (div_q),
    .tc    (tc)
  );

  assign nbits_ok = (n_bits != '0) && (n_bits <= MAX_N);
  // Edge count is even before a leading edge
  assign lead     = ~edge_q[0];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    nbits_d = nbits_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    phase_d = phase_q;
    edge_d  = edge_q;
    done_d  = 1'b0;
    smp_d   = 1'b0;
    shf_d   = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start && nbits_ok) begin
          div_d   = divider;
          nbits_d = n_bits;
          cpol_d  = cpol;
          cpha_d  = cpha;
          phase_d = 1'b0;
          edge_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          clr     = 1'b1;
          phase_d = 1'b0;
          state_d = IDLE;
        end else if (tc) begin
          phase_d = ~phase_q;
          edge_d  = edge_q + EW'(1);
          smp_d   = lead ^ cpha_q;
          shf_d   = ~(lead ^ cpha_q);
          if (edge_d == {nbits_q, 1'b0}) begin
            state_d = GUARD;
          end
        end
      end
      GUARD: begin
        if (abort) begin
          clr     = 1'b1;
          phase_d = 1'b0;
          state_d = IDLE;
        end else if (tc) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        clr     = 1'b1;
        phase_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clockIn or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      nbits_q <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      phase_q <= 1'b0;
      edge_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      smp_q   <= 1'b0;
      shf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      nbits_q <= nbits_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      phase_q <= phase_d;
      edge_q  <= edge_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      smp_q   <= smp_d;
      shf_q   <= shf_d;
    end
  end

  // Idle level tracks the live cpol pin, including during reset
  assign sclk          = (state_q == IDLE) ? cpol : (cpol_q ^ phase_q);
  assign sample_strobe = smp_q;
  assign shift_strobe  = shf_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed bench for spi_sclk_gen.
// A negedge monitor logs sclk edges and strobe/done/busy counts.
module tb_spi_sclk_gen;

  localparam int DW = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] divider = '0;
  logic [CW-1:0] n_bits = '0;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          sclk;
  logic          sample_strobe;
  logic          shift_strobe;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_fail = 0;

  int cyc = 0;
  logic sclk_p = 1'b0;
  int e_cyc[$];
  bit e_rise[$];
  int n_smp = 0, n_shf = 0, n_smp_r = 0, n_shf_f = 0;
  int n_done = 0, done_cyc = 0, n_busy = 0, n_bad = 0;

  spi_sclk_gen dut (
    .clockIn       (clk),
    .reset         (rst_n),
    .start         (start),
    .abort         (abort),
    .divider       (divider),
    .n_bits        (n_bits),
    .cpol          (cpol),
    .cpha          (cpha),
    .sclk          (sclk),
    .sample_strobe (sample_strobe),
    .shift_strobe  (shift_strobe),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sclk !== sclk_p) begin
      e_cyc.push_back(cyc);
      e_rise.push_back(sclk);
    end
    if ((sample_strobe || shift_strobe) && sclk === sclk_p) n_bad++;
    if (sample_strobe && shift_strobe) n_bad++;
    if (sample_strobe) begin
      n_smp++;
      if (sclk) n_smp_r++;
    end
    if (shift_strobe) begin
      n_shf++;
      if (!sclk) n_shf_f++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) n_busy++;
    sclk_p = sclk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic go(input int div, input int nb, input logic ph,
                    output int acc);
    @(posedge clk);
    #2;
    divider = DW'(div);
    n_bits  = CW'(nb);
    cpha    = ph;
    start   = 1'b1;
    acc     = cyc + 1;
    @(posedge clk);
    #2;
    start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    while (busy && k < max) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (busy) check({tag, "_timeout"}, 1, 0);
  endtask

  task automatic check_edges(input string tag, input int base,
                             input int n_exp, input int acc,
                             input int first, input int gap);
    int bad;
    bad = 0;
    check({tag, "_edges"}, e_cyc.size() - base, n_exp);
    if (e_cyc.size() > base)
      check({tag, "_first"}, e_cyc[base] - acc, first);
    for (int i = base + 1; i < e_cyc.size(); i++)
      if (e_cyc[i] - e_cyc[i-1] != gap) bad++;
    check({tag, "_gaps"}, bad, 0);
  endtask

  initial begin
    int acc, acc2, base, s0, h0, sr0, hf0, d0, b0, bad0, k;

    // Reset state; sclk follows cpol during reset
    cpol = 1'b1;
    #12;
    check("rst_sclk_hi", sclk, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", sample_strobe | shift_strobe, 0);
    cpol = 1'b0;
    #1;
    check("rst_sclk_lo", sclk, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Test 1: divider=3, 8 bits, mode 0
    base = e_cyc.size();
    s0 = n_smp; h0 = n_shf; sr0 = n_smp_r; hf0 = n_shf_f;
    d0 = n_done; b0 = n_busy; bad0 = n_bad;
    go(3, 8, 1'b0, acc);
    wait_idle("t1", 200);
    step(2);
    check_edges("t1", base, 16, acc, 4, 4);
    check("t1_smp", n_smp - s0, 8);
    check("t1_smp_rise", n_smp_r - sr0, 8);
    check("t1_shf", n_shf - h0, 8);
    check("t1_shf_fall", n_shf_f - hf0, 8);
    check("t1_done", n_done - d0, 1);
    check("t1_done_lat", done_cyc - e_cyc[e_cyc.size()-1], 4);
    check("t1_busy", n_busy - b0, 68);
    check("t1_align", n_bad - bad0, 0);

    // Test 2: divider=0, 1 bit, cpol=1 cpha=1
    cpol = 1'b1;
    step(3);
    base = e_cyc.size();
    s0 = n_smp; h0 = n_shf; sr0 = n_smp_r; hf0 = n_shf_f;
    d0 = n_done; b0 = n_busy;
    go(0, 1, 1'b1, acc);
    wait_idle("t2", 20);
    step(2);
    check_edges("t2", base, 2, acc, 1, 1);
    if (e_cyc.size() - base == 2) begin
      check("t2_dir1", e_rise[base], 0);
      check("t2_dir2", e_rise[base+1], 1);
    end
    check("t2_shf_fall", n_shf_f - hf0, 1);
    check("t2_smp_rise", n_smp_r - sr0, 1);
    check("t2_busy", n_busy - b0, 3);
    check("t2_done", n_done - d0, 1);

    // Test 3: abort two cycles after the 5th edge
    cpol = 1'b0;
    step(3);
    base = e_cyc.size();
    s0 = n_smp; h0 = n_shf; d0 = n_done;
    go(2, 4, 1'b0, acc);
    k = 0;
    while (e_cyc.size() - base < 5 && k < 100) begin
      step(1);
      k++;
    end
    check("t3_reach5", e_cyc.size() - base, 5);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    @(negedge clk);
    check("t3_busy", busy, 0);
    check("t3_sclk", sclk, 0);
    step(20);
    check("t3_edges", e_cyc.size() - base, 6);
    check("t3_strobes", (n_smp - s0) + (n_shf - h0), 5);
    check("t3_no_done", n_done - d0, 0);

    // Test 4: ignored starts (n_bits=0, n_bits>MAX_BITS, while busy)
    base = e_cyc.size();
    b0 = n_busy; s0 = n_smp; h0 = n_shf; d0 = n_done;
    go(1, 0, 1'b0, acc);
    step(5);
    go(1, 40, 1'b0, acc);
    step(5);
    check("t4_zero_busy", n_busy - b0, 0);
    check("t4_zero_edges", e_cyc.size() - base, 0);
    go(1, 2, 1'b0, acc);
    step(1);
    go(0, 3, 1'b1, acc2);
    wait_idle("t4", 50);
    step(2);
    check_edges("t4", base, 4, acc, 2, 2);
    check("t4_strobes", (n_smp - s0) + (n_shf - h0), 4);
    check("t4_busy", n_busy - b0, 10);
    check("t4_done", n_done - d0, 1);

    // Test 5: reset mid-RUN, then immediate start on release
    d0 = n_done;
    go(2, 4, 1'b0, acc);
    step(6);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_sclk", sclk, 0);
    check("t5_rst_strb", sample_strobe | shift_strobe, 0);
    step(2);
    base = e_cyc.size();
    divider = DW'(1);
    n_bits  = CW'(2);
    cpha    = 1'b0;
    start   = 1'b1;
    rst_n   = 1'b1;
    acc     = cyc + 1;
    step(1);
    start   = 1'b0;
    wait_idle("t5", 50);
    step(2);
    check_edges("t5", base, 4, acc, 2, 2);
    check("t5_done", n_done - d0, 1);

    // Test 6: divider change mid-transfer, start in the done cycle
    base = e_cyc.size();
    d0 = n_done;
    go(1, 2, 1'b0, acc);
    step(1);
    divider = DW'(5);
    k = 0;
    while (!done && k < 60) begin
      step(1);
      k++;
    end
    check("t6_done_seen", done, 1);
    divider = DW'(0);
    n_bits  = CW'(1);
    start   = 1'b1;
    acc2    = cyc + 1;
    step(1);
    start   = 1'b0;
    check("t6_busy_b2b", busy, 1);
    wait_idle("t6", 50);
    step(2);
    check("t6_edges", e_cyc.size() - base, 6);
    if (e_cyc.size() - base == 6) begin
      check("t6_a_first", e_cyc[base] - acc, 2);
      check("t6_a_last", e_cyc[base+3] - e_cyc[base+2], 2);
      check("t6_b_first", e_cyc[base+4] - acc2, 1);
    end
    check("t6_done", n_done - d0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, width of the half-period divider.
REQ-002 SHALL have parameter MAX_BITS, default 32, maximum bits per transfer; CNT_WIDTH = $clog2(MAX_BITS+1) is derived.
REQ-003 SHALL have port clockIn  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle transfer request.
REQ-006 SHALL have port abort  input  1  terminate the current transfer immediately.
REQ-007 SHALL have port divider  input  DIV_WIDTH  half-period length minus 1, in clockIn cycles.
REQ-008 SHALL have port n_bits  input  CNT_WIDTH  bits in the transfer, 1..MAX_BITS.
REQ-009 SHALL have port cpol  input  1  SCLK idle level.
REQ-010 SHALL have port cpha  input  1  0: sample on leading edge; 1: shift on leading edge.
REQ-011 SHALL have port sclk  output  1  serial clock, registered.
REQ-012 SHALL have port sample_strobe  output  1  one-cycle pulse on each sampling edge.
REQ-013 SHALL have port shift_strobe  output  1  one-cycle pulse on each shifting edge.
REQ-014 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at normal completion.

Function
REQ-016 SHALL implement states IDLE, RUN and GUARD.
REQ-017 In IDLE, start=1 with n_bits in 1..MAX_BITS SHALL latch divider, n_bits, cpol and cpha, clear the half-period and edge counters, set busy on the next cycle and enter RUN.
REQ-018 In IDLE, start with n_bits=0 or n_bits>MAX_BITS SHALL be ignored; start while busy SHALL be ignored.
REQ-019 In IDLE, sclk SHALL equal the live cpol input; in RUN and GUARD it SHALL equal the latched cpol XOR the internal phase.
REQ-020 The half-period counter SHALL count 0..divider_latched and wrap; each wrap in RUN SHALL toggle the phase and increment the edge counter.
REQ-021 The first sclk edge SHALL appear divider+1 clockIn cycles after the accept edge, and every subsequent edge SHALL follow divider+1 cycles after the previous one.
REQ-022 divider=0 SHALL give sclk = clockIn/2.
REQ-023 Odd edges (1st, 3rd, ...) SHALL be leading edges and even edges SHALL be trailing edges.
REQ-024 With cpha=0, sample_strobe SHALL pulse on leading edges and shift_strobe on trailing edges; with cpha=1 the roles SHALL swap.
REQ-025 Strobes SHALL be registered and coincide with the clockIn cycle in which the new sclk level is first visible; the two strobes SHALL never be high together.
REQ-026 After edge 2*n_bits, the block SHALL enter GUARD with sclk at the latched cpol for divider+1 cycles.
REQ-027 On the GUARD terminal count, done SHALL pulse for 1 cycle, busy SHALL fall in the same cycle, and the block SHALL return to IDLE.
REQ-028 start asserted in the done cycle SHALL be accepted, since the block is already in IDLE.
REQ-029 abort in RUN or GUARD SHALL force IDLE on the next edge: sclk=cpol, busy=0, no done, no further strobes; abort in IDLE SHALL have no effect.
REQ-030 If abort and the final edge coincide, abort SHALL win.
REQ-031 Changes to divider, n_bits, cpol or cpha while busy SHALL not affect the current transfer.
REQ-032 The edge counter SHALL be CNT_WIDTH+1 bits wide so that 2*MAX_BITS edges never wrap.

Reset
REQ-033 While reset=0, the block SHALL asynchronously force state=IDLE, counters=0, busy=0, done=0 and both strobes=0.
REQ-034 During reset, sclk SHALL equal cpol.
REQ-035 Reset mid-transfer SHALL behave as abort, with no done pulse.
REQ-036 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-037 A shared package spi_clk_pkg SHALL hold the state enum typedef (IDLE/RUN/GUARD) and the default DIV_WIDTH and MAX_BITS constants.
REQ-038 One sub-module sclk_prescaler SHALL provide the half-period counter, with load/clear and terminal-count output; all other logic SHALL reside in spi_sclk_gen.

Verification
REQ-039 Test: divider=3, n_bits=8, cpol=0, cpha=0, start. Required: 16 sclk edges, 4 cycles apart, first edge 4 cycles after accept; 8 sample_strobes on rising edges, 8 shift_strobes on falling edges; done 4 cycles after the last edge.
REQ-040 Test: divider=0, n_bits=1, cpol=1, cpha=1. Required: sclk 1->0->1 with 1-cycle half-periods; shift_strobe on the falling edge, sample_strobe on the rising edge; busy high for 3 cycles.
REQ-041 Test: abort 2 cycles after the 5th edge (divider=2, n_bits=4). Required: sclk=cpol and busy=0 on the next cycle; no done; no strobes thereafter.
REQ-042 Test: start with n_bits=0, then start while busy. Required: both ignored; busy and strobe counts unchanged.
REQ-043 Test: reset asserted mid-RUN, then released with an immediate start (divider=1, n_bits=2). Required: outputs cleared asynchronously; new transfer produces 4 edges, 2 cycles apart.
REQ-044 Test: start in the done cycle, with divider changed mid-transfer. Required: back-to-back transfer accepted; first transfer keeps its latched divider.
